// File: rtl/ps2_key_source.sv
// PS/2 keyboard line receiver: synchronizes and filters the raw clock/data pair,
// frames 11-bit PS/2 characters and turns accepted bytes into the 11-bit ps2_key event word.
module ps2_key_source #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 12000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic [10:0] ps2_key,
   output logic        err,
   output logic [1:0]  dbg_state_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_clk_q, filt_clk_d, filt_del_q, fall_q;
   logic [7:0]    filt_cnt_q, filt_cnt_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [10:0]   key_q, key_d;
   logic          err_q, err_d;
   logic          to_hit;

   // The filtered clock flips only after FILTER_LEN consecutive opposite samples.
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = 8'd0;
      if (clk_s2_q != filt_clk_q) begin
         if (filt_cnt_q == 8'(FILTER_LEN - 1)) begin
            filt_clk_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 8'd1;
         end
      end
   end

   assign to_hit = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT)) && !fall_q;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_ok_d  = par_ok_q;
      ext_d     = ext_q;
      rel_d     = rel_q;
      skip_d    = skip_q;
      key_d     = key_q;
      err_d     = 1'b0;
      to_cnt_d  = to_cnt_q;

      if (fall_q) begin
         to_cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_ok_d = dat_s2_q ^ (^shift_q);
               state_d  = ST_STOP;
            end
            default: begin
               state_d = ST_IDLE;
               if (dat_s2_q && par_ok_q) begin
                  // A nonzero skip count swallows the remainder of a Pause sequence.
                  if (skip_q != 3'd0) begin
                     skip_d = skip_q - 3'd1;
                  end else if (shift_q == 8'hE1) begin
                     skip_d = 3'd7;
                  end else if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     rel_d = 1'b1;
                  end else if (shift_q == 8'h00 || shift_q == 8'hFF || shift_q == 8'hAA ||
                               shift_q == 8'hEE || shift_q == 8'hFA || shift_q == 8'hFE) begin
                     ext_d = 1'b0;
                     rel_d = 1'b0;
                  end else begin
                     key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                     ext_d = 1'b0;
                     rel_d = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         endcase
      end else if (to_hit) begin
         state_d  = ST_IDLE;
         to_cnt_d = '0;
         err_d    = 1'b1;
      end else if (state_q != ST_IDLE) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end

      if (err_d) begin
         ext_d  = 1'b0;
         rel_d  = 1'b0;
         skip_d = 3'd0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_clk_q <= 1'b1;
         filt_del_q <= 1'b1;
         filt_cnt_q <= 8'd0;
         fall_q     <= 1'b0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         par_ok_q   <= 1'b0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         skip_q     <= 3'd0;
         to_cnt_q   <= '0;
         key_q      <= 11'd0;
         err_q      <= 1'b0;
      end else begin
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= ps2_data_in;
         dat_s2_q   <= dat_s1_q;
         filt_clk_q <= filt_clk_d;
         filt_del_q <= filt_clk_q;
         filt_cnt_q <= filt_cnt_d;
         fall_q     <= filt_del_q & ~filt_clk_q;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_ok_q   <= par_ok_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         skip_q     <= skip_d;
         to_cnt_q   <= to_cnt_d;
         key_q      <= key_d;
         err_q      <= err_d;
      end
   end

   assign ps2_key     = key_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_key_source.sv
// Bench for ps2_key_source: drives PS/2 frames at the pin level and compares the event word,
// error pulses and toggle flips against a byte-level keyboard-protocol model.
module tb_ps2_key_source;

   localparam int FL = 8;
   localparam int TO = 400;
   localparam int H  = 20;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        err;
   logic [1:0]  dbg_state;

   ps2_key_source #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk_sys     (clk),
      .reset_n     (reset_n),
      .ps2_clk_in  (ps2_clk),
      .ps2_data_in (ps2_data),
      .ps2_key     (ps2_key),
      .err         (err),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: counts err pulses, over-wide pulses and ps2_key[10] flips.
   logic mon_en = 1'b0;
   int   err_seen = 0;
   int   err_wide = 0;
   int   flips = 0;
   int   last_err_cyc = 0;
   logic err_prev = 1'b0;
   logic key10_prev = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (err) begin
            err_seen++;
            last_err_cyc = cyc;
         end
         if (err && err_prev) err_wide++;
         if (ps2_key[10] !== key10_prev) flips++;
      end
      err_prev   = err;
      key10_prev = ps2_key[10];
   end

   // Protocol-level reference model.
   logic [10:0] m_key = 11'd0;
   logic        m_ext = 1'b0;
   logic        m_rel = 1'b0;
   int          m_skip = 0;
   int          exp_err = 0;
   int          exp_flips = 0;

   task automatic model_error();
      exp_err++;
      m_ext  = 1'b0;
      m_rel  = 1'b0;
      m_skip = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_skip > 0) m_skip--;
      else if (b == 8'hE1) m_skip = 7;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (b inside {8'h00, 8'hFF, 8'hAA, 8'hEE, 8'hFA, 8'hFE}) begin
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else begin
         m_key = {~m_key[10], ~m_rel, m_ext, b};
         exp_flips++;
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   // Stimulus drivers; all pin changes happen just after a rising edge.
   int last_fall_cyc = 0;

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(H / 2);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(H);
      ps2_clk = 1'b1;
      wait_cyc(H / 2);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b) ^ bad_par);
      send_bit(~bad_stop);
      ps2_data = 1'b1;
      wait_cyc(2 * H);
      if (bad_par || bad_stop) model_error();
      else model_byte(b);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_key"}, 32'(ps2_key), 32'(m_key));
      check({tag, "_err"}, 32'(err_seen), 32'(exp_err));
      check({tag, "_flips"}, 32'(flips), 32'(exp_flips));
   endtask

   task automatic send_seq(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_frame(bytes[i], 1'b0, 1'b0);
   endtask

   initial begin
      int  kind;
      int  base_err;
      logic [7:0] b;
      logic in_win;

      wait_cyc(5);
      check("rst_key", 32'(ps2_key), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_state", 32'(dbg_state), 32'h0);
      reset_n = 1'b1;
      wait_cyc(3);
      mon_en = 1'b1;

      // Plain make code
      send_frame(8'h1C, 1'b0, 1'b0);
      check_state("plain");
      check("plain_word", 32'(ps2_key), 32'h61C);

      // Extended release: E0 F0 75 gives one event only
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      check_state("ext_prefix");
      send_frame(8'h75, 1'b0, 1'b0);
      check_state("ext_rel");
      check("ext_rel_low", 32'(ps2_key[9:0]), 32'h175);

      // Parity error clears the pending release prefix
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h29, 1'b1, 1'b0);
      check_state("par_err");
      send_frame(8'h29, 1'b0, 1'b0);
      check_state("par_recover");
      check("par_recover_low", 32'(ps2_key[9:0]), 32'h229);

      // Status code then the full Pause sequence are discarded
      send_seq('{8'hAA, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
      check_state("pause");
      send_frame(8'h16, 1'b0, 1'b0);
      check_state("after_pause");
      check("after_pause_low", 32'(ps2_key[9:0]), 32'h216);

      // Short clock glitch must be ignored
      ps2_clk = 1'b0;
      wait_cyc(FL - 2);
      ps2_clk = 1'b1;
      wait_cyc(40);
      check_state("glitch");
      check("glitch_state", 32'(dbg_state), 32'h0);

      // Partial frame after an E0 prefix: timeout aborts and drops the prefix
      send_frame(8'hE0, 1'b0, 1'b0);
      base_err = err_seen;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int i = 0; i < TO + 200 && err_seen == base_err; i++) wait_cyc(1);
      model_error();
      check_state("timeout");
      in_win = (last_err_cyc - last_fall_cyc >= TO) && (last_err_cyc - last_fall_cyc <= TO + FL + 10);
      check("timeout_window", 32'(in_win), 32'h1);
      send_frame(8'h1C, 1'b0, 1'b0);
      check_state("after_timeout");

      // Reset mid-frame after a release prefix
      send_frame(8'hF0, 1'b0, 1'b0);
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      mon_en = 1'b0;
      reset_n = 1'b0;
      wait_cyc(1);
      reset_n = 1'b1;
      wait_cyc(3);
      m_key = 11'd0;
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_skip = 0;
      mon_en = 1'b1;
      wait_cyc(2 * H);
      check_state("reset_mid");
      send_frame(8'h1C, 1'b0, 1'b0);
      check_state("after_reset");
      check("after_reset_word", 32'(ps2_key), 32'h61C);

      // Randomized traffic
      for (int n = 0; n < 24; n++) begin
         kind = $urandom_range(0, 5);
         b = 8'($urandom_range(8'h01, 8'h7F));
         case (kind)
            0: send_frame(b, 1'b0, 1'b0);
            1: send_seq('{8'hE0, b});
            2: send_seq('{8'hF0, b});
            3: send_seq('{8'hE0, 8'hF0, b});
            4: send_frame(($urandom_range(0, 1) != 0) ? 8'hAA : 8'hFA, 1'b0, 1'b0);
            default: begin
               send_frame(8'hE0, 1'b0, 1'b0);
               if ($urandom_range(0, 1) != 0) send_frame(b, 1'b1, 1'b0);
               else send_frame(b, 1'b0, 1'b1);
            end
         endcase
         check_state($sformatf("rand%0d", n));
      end

      check("err_width", 32'(err_wide), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
